// File: rtl/time_pkg.sv
// Shared definitions for the time register controller: field codes, FSM
// state codes, BCD limits, the write-back payload and a field-to-enable decode.
package time_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned EN_W   = 3;

  // Field codes shared by rtc_sel, fld_sel and wb_sel
  localparam logic [SEL_W-1:0] SEL_SEG  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MIN  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_HORA = 2'b10;
  localparam logic [SEL_W-1:0] SEL_NONE = 2'b11;

  // Controller state enumeration
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD    = 3'd1;
  localparam logic [ST_W-1:0] ST_EDIT    = 3'd2;
  localparam logic [ST_W-1:0] ST_STEP    = 3'd3;
  localparam logic [ST_W-1:0] ST_WB_REQ  = 3'd4;
  localparam logic [ST_W-1:0] ST_WB_WAIT = 3'd5;

  // BCD limits
  localparam logic [DATA_W-1:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [DATA_W-1:0] BCD_MS_MAX   = 8'h59;

  // Step direction
  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_INC = 1'b1;

  // Write-back payload presented to the RTC write engine
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_pay_t;

  // One-hot {hora, min, seg} enable for a field code; SEL_NONE gives no enable
  function automatic logic [EN_W-1:0] sel_to_en(input logic [SEL_W-1:0] sel);
    logic [EN_W-1:0] en;
    en = '0;
    case (sel)
      SEL_SEG:  en = 3'b001;
      SEL_MIN:  en = 3'b010;
      SEL_HORA: en = 3'b100;
      default:  en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/time_reg_ctrl_bcd_step.sv
// bcd_step: combinational BCD +/-1 with wrap.
//   value      : current BCD byte
//   max        : BCD maximum of the field
//   dir        : DIR_INC or DIR_DEC
//   next_value : stepped BCD byte
// Malformed input (a nibble above 9, or above max) snaps to 00 on inc and to
// max on dec so a corrupted register always recovers to a legal value.
module bcd_step
  import time_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] max,
  input  logic              dir,
  output logic [DATA_W-1:0] next_value
);

  logic [3:0] units;
  logic [3:0] tens;
  logic       bad;

  assign units = value[3:0];
  assign tens  = value[7:4];
  assign bad   = (units > 4'd9) || (tens > 4'd9) || (value > max);

  // Step with units carry/borrow and field wrap
  always_comb begin
    next_value = '0;
    if (dir == DIR_INC) begin
      if (bad || (value == max)) begin
        next_value = '0;
      end else if (units == 4'd9) begin
        next_value = {tens + 4'd1, 4'd0};
      end else begin
        next_value = {tens, units + 4'd1};
      end
    end else begin
      if (bad || (value == '0)) begin
        next_value = max;
      end else if (units == 4'd0) begin
        next_value = {tens - 4'd1, 4'd9};
      end else begin
        next_value = {tens, units - 4'd1};
      end
    end
  end

endmodule

// File: rtl/time_reg_ctrl.sv
// time_reg_ctrl: arbitrates writes to the sec/min/hour BCD time registers
// between the RTC read engine and a user edit session, and requests a
// write-back to the RTC after every user step.
//   clk, reset                  : clock, synchronous active-high reset
//   rtc_vld/rtc_sel/rtc_data    : RTC byte offer; rtc_rdy accepts it
//   edit_mode, fld_sel, inc, dec: user edit session controls
//   q_seg, q_min, q_hora        : current time register contents
//   d_out, en_seg/min/hora      : shared data bus and one-hot load enables
//   wb_req/wb_sel/wb_data/wb_ack: write-back handshake to the RTC write engine
//   busy                        : high outside IDLE and EDIT
// All outputs are registered: each is computed from the next state.
module time_reg_ctrl
  import time_pkg::*;
#(
  parameter logic [7:0] HOUR_MAX = 8'h23,
  parameter logic [7:0] MS_MAX   = 8'h59
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rtc_vld,
  input  logic [SEL_W-1:0]  rtc_sel,
  input  logic [DATA_W-1:0] rtc_data,
  output logic              rtc_rdy,
  input  logic              edit_mode,
  input  logic [SEL_W-1:0]  fld_sel,
  input  logic              inc,
  input  logic              dec,
  input  logic [DATA_W-1:0] q_seg,
  input  logic [DATA_W-1:0] q_min,
  input  logic [DATA_W-1:0] q_hora,
  output logic [DATA_W-1:0] d_out,
  output logic              en_seg,
  output logic              en_min,
  output logic              en_hora,
  output logic              wb_req,
  output logic [SEL_W-1:0]  wb_sel,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ack,
  output logic              busy
);

  logic [ST_W-1:0]   state,     nxt_state;
  logic [SEL_W-1:0]  fld_r,     nxt_fld;
  logic [DATA_W-1:0] d_out_r,   nxt_d_out;
  logic [EN_W-1:0]   en_r,      nxt_en;
  logic              wb_req_r,  nxt_wb_req;
  wb_pay_t           wb_r,      nxt_wb;
  logic              busy_r,    nxt_busy;
  logic              rdy_r,     nxt_rdy;

  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] step_max;
  logic [DATA_W-1:0] step_next;
  logic              step_ok;

  // Field under edit and its limit feed the stepper
  always_comb begin
    step_q = q_hora;
    case (fld_sel)
      SEL_SEG: step_q = q_seg;
      SEL_MIN: step_q = q_min;
      default: step_q = q_hora;
    endcase
  end

  assign step_max = (fld_sel == SEL_HORA) ? HOUR_MAX : MS_MAX;
  assign step_ok  = (inc ^ dec) && (fld_sel != SEL_NONE);

  bcd_step u_bcd_step (
    .value      (step_q),
    .max        (step_max),
    .dir        (inc),
    .next_value (step_next)
  );

  // Next-state and next-output logic
  always_comb begin
    nxt_state  = state;
    nxt_fld    = fld_r;
    nxt_d_out  = d_out_r;
    nxt_en     = '0;
    nxt_wb_req = 1'b0;
    nxt_wb     = wb_r;
    nxt_busy   = 1'b0;
    nxt_rdy    = 1'b0;

    case (state)
      ST_IDLE: begin
        // An edit session wins over a byte offered in the same cycle
        if (edit_mode) begin
          nxt_state = ST_EDIT;
        end else if (rtc_vld && rdy_r) begin
          nxt_state = ST_LOAD;
          nxt_d_out = rtc_data;
          nxt_en    = sel_to_en(rtc_sel);
        end
      end
      ST_LOAD: begin
        nxt_state = ST_IDLE;
      end
      ST_EDIT: begin
        if (!edit_mode) begin
          nxt_state = ST_IDLE;
        end else if (step_ok) begin
          nxt_state = ST_STEP;
          nxt_fld   = fld_sel;
          nxt_d_out = step_next;
          nxt_en    = sel_to_en(fld_sel);
        end
      end
      ST_STEP: begin
        // d_out still holds the value loaded this cycle
        nxt_state   = ST_WB_REQ;
        nxt_wb_req  = 1'b1;
        nxt_wb.sel  = fld_r;
        nxt_wb.data = d_out_r;
      end
      ST_WB_REQ: begin
        if (wb_ack) begin
          nxt_state = ST_WB_WAIT;
        end else begin
          nxt_wb_req = 1'b1;
        end
      end
      ST_WB_WAIT: begin
        nxt_state = edit_mode ? ST_EDIT : ST_IDLE;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase

    nxt_busy = (nxt_state != ST_IDLE) && (nxt_state != ST_EDIT);
    nxt_rdy  = (nxt_state == ST_IDLE) && !edit_mode;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      fld_r    <= SEL_SEG;
      d_out_r  <= '0;
      en_r     <= '0;
      wb_req_r <= 1'b0;
      wb_r     <= '0;
      busy_r   <= 1'b0;
      rdy_r    <= 1'b0;
    end else begin
      state    <= nxt_state;
      fld_r    <= nxt_fld;
      d_out_r  <= nxt_d_out;
      en_r     <= nxt_en;
      wb_req_r <= nxt_wb_req;
      wb_r     <= nxt_wb;
      busy_r   <= nxt_busy;
      rdy_r    <= nxt_rdy;
    end
  end

  assign d_out   = d_out_r;
  assign en_seg  = en_r[0];
  assign en_min  = en_r[1];
  assign en_hora = en_r[2];
  assign wb_req  = wb_req_r;
  assign wb_sel  = wb_r.sel;
  assign wb_data = wb_r.data;
  assign busy    = busy_r;
  assign rtc_rdy = rdy_r;

endmodule

// File: tb/tb_time_reg_ctrl.sv
// Directed bench for time_reg_ctrl: RTC loads, user steps with BCD wrap,
// write-back handshake, dropped pulses, edit exit and reset mid write-back.
module tb_time_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rtc_vld;
  logic [1:0] rtc_sel;
  logic [7:0] rtc_data;
  logic       rtc_rdy;
  logic       edit_mode;
  logic [1:0] fld_sel;
  logic       inc, dec;
  logic [7:0] q_seg, q_min, q_hora;
  logic [7:0] d_out;
  logic       en_seg, en_min, en_hora;
  logic       wb_req;
  logic [1:0] wb_sel;
  logic [7:0] wb_data;
  logic       wb_ack;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  time_reg_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rtc_vld   (rtc_vld),
    .rtc_sel   (rtc_sel),
    .rtc_data  (rtc_data),
    .rtc_rdy   (rtc_rdy),
    .edit_mode (edit_mode),
    .fld_sel   (fld_sel),
    .inc       (inc),
    .dec       (dec),
    .q_seg     (q_seg),
    .q_min     (q_min),
    .q_hora    (q_hora),
    .d_out     (d_out),
    .en_seg    (en_seg),
    .en_min    (en_min),
    .en_hora   (en_hora),
    .wb_req    (wb_req),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .wb_ack    (wb_ack),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ens();
    return {en_hora, en_min, en_seg};
  endfunction

  // One user step from EDIT through write-back and back to EDIT
  task automatic user_step(input string tag, input logic [1:0] sel, input logic [7:0] q,
                           input logic up, input logic [7:0] exp);
    logic [2:0] exp_en;
    exp_en = (sel == 2'b00) ? 3'b001 : (sel == 2'b01) ? 3'b010 : 3'b100;
    fld_sel = sel;
    q_seg  = (sel == 2'b00) ? q : 8'h11;
    q_min  = (sel == 2'b01) ? q : 8'h11;
    q_hora = (sel == 2'b10) ? q : 8'h11;
    inc = up;
    dec = !up;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    chk({tag, "_dout"}, 32'(d_out), 32'(exp));
    chk({tag, "_en"}, 32'(ens()), 32'(exp_en));
    tick();
    chk({tag, "_wb"}, {21'd0, wb_req, wb_sel, wb_data}, {21'd0, 1'b1, sel, exp});
    chk({tag, "_wb_en"}, 32'(ens()), 32'd0);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    tick();
    chk({tag, "_back"}, {30'd0, busy, wb_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rtc_vld = 1'b0; rtc_sel = 2'b00; rtc_data = 8'h00;
    edit_mode = 1'b0; fld_sel = 2'b00; inc = 1'b0; dec = 1'b0;
    q_seg = 8'h00; q_min = 8'h00; q_hora = 8'h00; wb_ack = 1'b0;
    tick();
    tick();
    chk("rst_dout", 32'(d_out), 32'd0);
    chk("rst_ctl", {26'd0, rtc_rdy, busy, wb_req, ens()}, 32'd0);
    chk("rst_wb", {22'd0, wb_sel, wb_data}, 32'd0);

    reset = 1'b0;
    tick();
    chk("rdy_after_rst", {30'd0, rtc_rdy, busy}, 32'b10);

    // RTC load of the hour field
    rtc_vld = 1'b1; rtc_sel = 2'b10; rtc_data = 8'h17;
    tick();
    rtc_vld = 1'b0;
    chk("load_hora_dout", 32'(d_out), 32'h17);
    chk("load_hora_en", 32'(ens()), 32'b100);
    chk("load_hora_ctl", {30'd0, rtc_rdy, busy}, 32'b01);
    tick();
    chk("load_hora_end", {27'd0, rtc_rdy, busy, ens()}, {27'd0, 2'b10, 3'b000});

    // RTC load of the second field
    rtc_vld = 1'b1; rtc_sel = 2'b00; rtc_data = 8'h33;
    tick();
    rtc_vld = 1'b0;
    chk("load_seg", {21'd0, ens(), d_out}, {21'd0, 3'b001, 8'h33});
    tick();

    // Invalid field code is consumed without any enable
    rtc_vld = 1'b1; rtc_sel = 2'b11; rtc_data = 8'h42;
    tick();
    rtc_vld = 1'b0;
    chk("load_none", {28'd0, busy, ens()}, {28'd0, 1'b1, 3'b000});
    tick();
    chk("load_none_end", 32'(rtc_rdy), 32'd1);

    // Edit session wins over a same-cycle RTC offer; no transfer during edit
    edit_mode = 1'b1;
    rtc_vld = 1'b1; rtc_sel = 2'b00; rtc_data = 8'h11;
    tick();
    chk("edit_prio", {27'd0, rtc_rdy, busy, ens()}, 32'd0);
    tick();
    chk("edit_no_rtc", {27'd0, rtc_rdy, busy, ens()}, 32'd0);
    rtc_vld = 1'b0;

    // Minute 59 inc wraps to 00; dropped pulse while WB_REQ
    fld_sel = 2'b01; q_min = 8'h59;
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("min_wrap_dout", 32'(d_out), 32'h00);
    chk("min_wrap_en", 32'(ens()), 32'b010);
    tick();
    chk("min_wb", {21'd0, wb_req, wb_sel, wb_data}, {21'd0, 1'b1, 2'b01, 8'h00});
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("min_wb_hold", {18'd0, ens(), wb_req, wb_sel, wb_data}, {18'd0, 3'b000, 1'b1, 2'b01, 8'h00});
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("min_wb_wait", {30'd0, busy, wb_req}, 32'b10);
    tick();
    chk("min_back_edit", {27'd0, rtc_rdy, busy, ens()}, 32'd0);
    tick();
    chk("min_pulse_dropped", 32'(ens()), 32'd0);

    // BCD step cases
    user_step("hora_dec_wrap", 2'b10, 8'h00, 1'b0, 8'h23);
    user_step("seg_inc_carry", 2'b00, 8'h09, 1'b1, 8'h10);
    user_step("seg_inc_bad",   2'b00, 8'h3C, 1'b1, 8'h00);
    user_step("seg_dec_wrap",  2'b00, 8'h00, 1'b0, 8'h59);
    user_step("min_dec_borrow",2'b01, 8'h40, 1'b0, 8'h39);
    user_step("hora_inc_wrap", 2'b10, 8'h23, 1'b1, 8'h00);
    user_step("hora_dec_above",2'b10, 8'h24, 1'b0, 8'h23);
    user_step("seg_dec_bad",   2'b00, 8'h5A, 1'b0, 8'h59);
    user_step("hora_inc_carry",2'b10, 8'h19, 1'b1, 8'h20);

    // inc and dec together, and the invalid field, are ignored
    fld_sel = 2'b00; q_seg = 8'h05;
    inc = 1'b1; dec = 1'b1;
    tick();
    inc = 1'b0; dec = 1'b0;
    chk("both_ignored", {28'd0, busy, ens()}, 32'd0);
    tick();
    chk("both_no_wb", 32'(wb_req), 32'd0);
    fld_sel = 2'b11; inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("none_ignored", {28'd0, busy, ens()}, 32'd0);

    // Edit exit mid write-back completes the write-back first
    fld_sel = 2'b00; q_seg = 8'h05; inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("exit_step", {21'd0, ens(), d_out}, {21'd0, 3'b001, 8'h06});
    tick();
    edit_mode = 1'b0;
    tick();
    chk("exit_wb_held", {20'd0, busy, wb_req, wb_sel, wb_data}, {20'd0, 1'b1, 1'b1, 2'b00, 8'h06});
    tick();
    chk("exit_wb_held2", 32'(wb_req), 32'd1);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("exit_wb_wait", {30'd0, busy, wb_req}, 32'b10);
    tick();
    chk("exit_idle", {30'd0, rtc_rdy, busy}, 32'b10);

    // Edit exit straight from EDIT
    edit_mode = 1'b1;
    tick();
    chk("edit_enter", 32'(rtc_rdy), 32'd0);
    edit_mode = 1'b0;
    tick();
    chk("edit_leave", {30'd0, rtc_rdy, busy}, 32'b10);

    // Reset during WB_REQ clears every output next cycle
    edit_mode = 1'b1;
    tick();
    fld_sel = 2'b01; q_min = 8'h07; inc = 1'b1;
    tick();
    inc = 1'b0;
    tick();
    chk("rst_wb_pre", {21'd0, wb_req, wb_sel, wb_data}, {21'd0, 1'b1, 2'b01, 8'h08});
    reset = 1'b1;
    tick();
    chk("rst_wb_ctl", {26'd0, rtc_rdy, busy, wb_req, ens()}, 32'd0);
    chk("rst_wb_bus", {14'd0, wb_sel, wb_data, d_out}, 32'd0);
    reset = 1'b0;
    edit_mode = 1'b0;
    tick();
    chk("rst_wb_rdy", 32'(rtc_rdy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
